// File: rtl/accum_feeder_pkg.sv
// accum_feeder_pkg: shared FSM state type and default sizing for accum_feeder
package accum_feeder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_W     = 32;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NITER = 100;
endpackage

// File: rtl/accum_feeder_fifo.sv
// accum_feeder_fifo: DEPTH x W sample buffer with full/empty flags and occupancy level
module accum_feeder_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout  = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(rd);
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/accum_feeder.sv
// accum_feeder: buffers upstream samples and issues NITER of them per run to an accumulator.
// Define ACCUM_FEEDER_ZERO_PAD_EN to issue x=0 on empty-buffer cycles instead of stalling.
module accum_feeder
  import accum_feeder_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NITER = DEF_NITER
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         en,
  output logic [W-1:0] x,
  output logic         busy,
  output logic         done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP  = (AW+1)'(DEPTH);
  localparam logic [6:0]  LAST = 7'(NITER);
  state_t state;
  logic [6:0] cnt;
  logic [AW:0] level;
  logic [W-1:0] head;
  logic full, empty, last, issue, pop, fire;
  assign last  = cnt == LAST;
  assign issue = state == RUN && !last;
  assign pop   = issue && !empty;
`ifdef ACCUM_FEEDER_ZERO_PAD_EN
  assign fire = issue;
`else
  assign fire = pop;
`endif
  assign in_ready = rst && level < CAP;
  accum_feeder_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && !full),
    .pop   (pop),
    .din   (in_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );
  // cnt counts issued en cycles; it is held at zero while idle so each run starts fresh
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      en    <= 1'b0;
      x     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
      cnt   <= state == IDLE ? '0 : cnt + 7'(fire);
      en    <= fire;
      x     <= pop ? head : '0;
      busy  <= state == IDLE ? start : state == RUN;
      done  <= state == RUN && last;
    end
endmodule

// File: tb/tb_accum_feeder.sv
// tb_accum_feeder: randomized self-checking bench for accum_feeder against a queue-based reference model
module tb_accum_feeder;
  localparam int W = 32;
  localparam int DEPTH = 8;
  localparam int NITER = 100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, en, busy, done;
  logic [W-1:0] x;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int run_en = 0;
  int n_done = 0;
  int start_cyc = 0;
  logic [W-1:0] q[$];
  bit m_run = 0;
  int m_iss = 0;
  int m_n = 0;
  bit m_fin = 0;
  logic m_en = 1'b0;
  logic m_done = 1'b0;
  logic m_busy = 1'b0;
  logic [W-1:0] m_x = '0;

  accum_feeder #(.W(W), .DEPTH(DEPTH), .NITER(NITER)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en(en), .x(x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: a queue of accepted samples plus run bookkeeping; a run hands out
  // NITER samples (or pads) one per cycle, then reports done one cycle later.
  always @(posedge clk or negedge rst)
    if (!rst) begin
      q.delete();
      m_run = 0; m_iss = 0; m_en = 0; m_x = '0; m_done = 0; m_busy = 0;
    end else begin
      m_n = q.size();
      m_fin = m_done;
      m_en = 0; m_x = '0; m_done = 0;
      if (m_fin) m_busy = 0;
      else if (m_run && m_iss == NITER) begin m_run = 0; m_done = 1; end
      else if (m_run) begin
        if (m_n > 0) begin m_en = 1; m_x = q.pop_front(); m_iss++; end
`ifdef ACCUM_FEEDER_ZERO_PAD_EN
        else begin m_en = 1; m_iss++; end
`endif
      end else if (start) begin m_run = 1; m_iss = 0; m_busy = 1; end
      if (in_valid && m_n < DEPTH) q.push_back(in_data);
    end

  always @(negedge clk) begin
    check("en", en, m_en);
    check("x", x, m_x);
    check("done", done, m_done);
    check("busy", busy, m_busy);
    check("in_ready", in_ready, rst && q.size() < DEPTH);
    if (!rst) run_en = 0;
    else begin
      if (en) run_en++;
      if (done) begin
        check("run_len", run_en, NITER);
        run_en = 0;
        n_done++;
      end
    end
  end

  task automatic tick(input bit v, input bit s);
    @(negedge clk); #1;
    in_valid = v;
    in_data = $urandom;
    start = s;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 0; in_valid = 0; start = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1;
  endtask

  // streams every `period` cycles; with poke, re-pulses start while a run is active (must be ignored)
  task automatic wait_done(input int lim, input int period, input bit poke);
    int base;
    base = n_done;
    for (int i = 0; i < lim && n_done == base; i++) begin
      @(negedge clk); #1;
      in_valid = (i % period) == 0;
      in_data = $urandom;
      start = poke && (m_run || m_done) && ($urandom_range(0, 3) == 0);
    end
    start = 0;
    in_valid = 0;
    check("done_seen", n_done - base, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    #1 rst = 1;
    // preload to full, extra valids refused, then a back-to-back run
    repeat (DEPTH + 2) tick(1, 0);
    @(negedge clk);
    check("full_ready", in_ready, 1'b0);
    #1 start = 1; in_valid = 1; in_data = $urandom;
    start_cyc = cyc;
    tick(1, 0);
    check("lat_c1", en, 1'b0);
    tick(1, 0);
    check("lat_c2", en, 1'b1);
    wait_done(400, 1, 0);
    check("done_at_full", cyc - start_cyc, NITER + 2);
    // sparse upstream: one sample every third cycle, with stray start pulses
    do_reset();
    tick(0, 1);
    start_cyc = cyc;
    wait_done(1500, 3, 1);
`ifdef ACCUM_FEEDER_ZERO_PAD_EN
    check("done_at_pad", cyc - start_cyc, NITER + 2);
`endif
    // random traffic and random starts
    for (int i = 0; i < 600; i++) tick($urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    // reset in the middle of a run
    do_reset();
    tick(1, 1);
    for (int i = 0; i < 300 && run_en < 40; i++) tick(1, 0);
    check("reached_40", run_en, 40);
    rst = 0;
    #1;
    check("abort_en", en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_x", x, 0);
    check("abort_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1; in_valid = 0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);
    #1 start = 1; in_valid = 1; in_data = $urandom;
    wait_done(600, 1, 1);
    repeat (4) tick(0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
